// File: rtl/sdram_mem_tester.sv
// Memory test initiator for the sdram_controller request port. It writes an address/seed
// pattern over 0..LAST_ADDR, reads the words back and compares them, then repeats with seed+1.
module sdram_mem_tester #(
  parameter int unsigned        ADDR_W    = 22,
  parameter logic [ADDR_W-1:0]  LAST_ADDR = '1,
  parameter int unsigned        TIMEOUT   = 255
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              enable,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              busy,
  output logic [1:0]        phase,
  output logic [15:0]       pass_count,
  output logic [15:0]       err_count,
  output logic              fail,
  output logic              timeout_seen,
  output logic [ADDR_W-1:0] err_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_RD_REQ,
    S_RD_WAIT,
    S_PASS_END
  } state_t;

  localparam logic [15:0]       TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          seed_q, seed_d;
  logic [15:0]         tmo_q, tmo_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic [1:0]          phase_q, phase_d;
  logic [15:0]         pass_count_q, pass_count_d;
  logic [15:0]         err_count_q, err_count_d;
  logic                fail_q, fail_d;
  logic                timeout_seen_q, timeout_seen_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic                err_ev;
  logic                rd_done;

  // Address bits above 15 never reach the pattern; narrower addresses zero-extend.
  function automatic logic [15:0] pat(input logic [ADDR_W-1:0] a, input logic [7:0] s);
    return 16'(a) ^ {s, ~s};
  endfunction

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    seed_d         = seed_q;
    tmo_d          = tmo_q;
    pass_count_d   = pass_count_q;
    err_count_d    = err_count_q;
    fail_d         = fail_q;
    timeout_seen_d = timeout_seen_q;
    err_addr_d     = err_addr_q;
    err_ev         = 1'b0;
    rd_done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          addr_d  = '0;
          state_d = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        if (mem_ack) begin
          if (addr_q == LAST_ADDR) begin
            addr_d  = '0;
            state_d = S_RD_REQ;
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
        end
      end
      S_RD_REQ: begin
        if (mem_ack) begin
          tmo_d   = '0;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        // Data arriving on the expiry cycle wins over the timeout.
        if (mem_rvalid) begin
          rd_done = 1'b1;
          err_ev  = (mem_rdata != pat(addr_q, seed_q));
        end else if (tmo_q == TMO_LAST) begin
          rd_done        = 1'b1;
          err_ev         = 1'b1;
          timeout_seen_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
        if (rd_done) begin
          if (addr_q == LAST_ADDR) begin
            state_d = S_PASS_END;
          end else begin
            addr_d  = addr_q + ADDR_ONE;
            state_d = S_RD_REQ;
          end
        end
      end
      S_PASS_END: begin
        pass_count_d = pass_count_q + 16'd1;
        seed_d       = seed_q + 8'd1;
        if (enable) begin
          addr_d  = '0;
          state_d = S_WR_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (err_ev) begin
      if (err_count_q != '1) err_count_d = err_count_q + 16'd1;
      fail_d = 1'b1;
      if (!fail_q) err_addr_d = addr_q;
    end
  end

  // Request outputs are registered from the next state so they line up with it.
  always_comb begin
    req_d   = (state_d == S_WR_REQ) || (state_d == S_RD_REQ);
    we_d    = (state_d == S_WR_REQ);
    wdata_d = (state_d == S_WR_REQ) ? pat(addr_d, seed_d) : wdata_q;
    busy_d  = (state_d != S_IDLE);
    case (state_d)
      S_WR_REQ:             phase_d = 2'd1;
      S_RD_REQ, S_RD_WAIT:  phase_d = 2'd2;
      S_PASS_END:           phase_d = 2'd3;
      default:              phase_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      seed_q         <= '0;
      tmo_q          <= '0;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      wdata_q        <= '0;
      busy_q         <= 1'b0;
      phase_q        <= '0;
      pass_count_q   <= '0;
      err_count_q    <= '0;
      fail_q         <= 1'b0;
      timeout_seen_q <= 1'b0;
      err_addr_q     <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      seed_q         <= seed_d;
      tmo_q          <= tmo_d;
      req_q          <= req_d;
      we_q           <= we_d;
      wdata_q        <= wdata_d;
      busy_q         <= busy_d;
      phase_q        <= phase_d;
      pass_count_q   <= pass_count_d;
      err_count_q    <= err_count_d;
      fail_q         <= fail_d;
      timeout_seen_q <= timeout_seen_d;
      err_addr_q     <= err_addr_d;
    end
  end

  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign busy         = busy_q;
  assign phase        = phase_q;
  assign pass_count   = pass_count_q;
  assign err_count    = err_count_q;
  assign fail         = fail_q;
  assign timeout_seen = timeout_seen_q;
  assign err_addr     = err_addr_q;

endmodule
